// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, scanner states and the matrix position to code map
package keypad_pkg;
  localparam logic [3:0] KEY_0 = 4'd0, KEY_1 = 4'd1, KEY_2 = 4'd2, KEY_3 = 4'd3;
  localparam logic [3:0] KEY_4 = 4'd4, KEY_5 = 4'd5, KEY_6 = 4'd6, KEY_7 = 4'd7;
  localparam logic [3:0] KEY_8 = 4'd8, KEY_9 = 4'd9, KEY_STAR = 4'd10, KEY_TAG = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'b1111;
  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_EMIT, ST_WAIT_RELEASE} state_e;
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return (row != 2'd3) ? {2'b0, row} * 4'd3 + {2'b0, col} + 4'd1 :
           (col == 2'd0) ? KEY_STAR : (col == 2'd1) ? KEY_0 : KEY_TAG;
  endfunction
endpackage

// File: rtl/keypad_col_sync.sv
// keypad_col_sync: 2-flop synchroniser for the column returns, idles high
module keypad_col_sync (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:1] d_i,
  output logic [3:1] q_o
);
  logic [3:1] s1_q, s2_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  assign q_o = s2_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x3 active-low key matrix and emits debounced one-cycle key codes
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:1] col_n,
  output logic [4:1] row_n,
  output logic [4:1] key_code,
  output logic       key_valid
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic [3:1] cols;
  state_e state_q;
  logic [DW-1:0] div_q;
  logic [CW-1:0] cnt_q, cnt_inc;
  logic [1:0] row_q, col_q, hit_col;
  logic [4:1] row_n_q;
  logic [3:0] code_q;
  logic valid_q, sample, hit, deb_done;
  keypad_col_sync u_sync (.clk_i(clk), .rst_ni(rst), .d_i(col_n), .q_o(cols));
  always_comb begin
    sample = div_q == DW'(SCAN_DIV - 1);
    hit = cols inside {3'b110, 3'b101, 3'b011};
    hit_col = !cols[1] ? 2'd0 : (!cols[2] ? 2'd1 : 2'd2);
    cnt_inc = (cnt_q == CW'(DEBOUNCE)) ? cnt_q : cnt_q + CW'(1);
    deb_done = cnt_inc == CW'(DEBOUNCE);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= ST_SCAN;
      div_q <= '0;
      row_q <= '0;
      row_n_q <= 4'b1110;
      col_q <= '0;
      cnt_q <= '0;
      code_q <= KEY_NONE;
      valid_q <= 1'b0;
    end else begin
      div_q <= sample ? '0 : div_q + DW'(1);
      code_q <= KEY_NONE;
      valid_q <= 1'b0;
      case (state_q)
        ST_SCAN: if (sample) begin
          if (hit) begin
            col_q <= hit_col;
            cnt_q <= CW'(1);
            state_q <= (DEBOUNCE == 1) ? ST_EMIT : ST_DEBOUNCE;
          end else begin
            row_q <= row_q + 2'd1;
            row_n_q <= {row_n_q[3:1], row_n_q[4]};
          end
        end
        ST_DEBOUNCE: if (sample) begin
          if (hit && hit_col == col_q) begin
            cnt_q <= cnt_inc;
            if (deb_done) state_q <= ST_EMIT;
          end else begin
            state_q <= ST_SCAN;
            row_q <= '0;
            row_n_q <= 4'b1110;
            cnt_q <= '0;
          end
        end
        ST_EMIT: begin
          code_q <= key_lookup(row_q, col_q);
          valid_q <= 1'b1;
          cnt_q <= '0;
          state_q <= ST_WAIT_RELEASE;
        end
        default: if (sample) begin
          if (&cols && deb_done) begin
            state_q <= ST_SCAN;
            row_q <= '0;
            row_n_q <= 4'b1110;
            cnt_q <= '0;
          end else cnt_q <= &cols ? cnt_inc : '0;
        end
      endcase
    end
  assign row_n = row_n_q;
  assign key_code = code_q;
  assign key_valid = valid_q;
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad front end that produces the 4-bit keypad code stream consumed by the Elevator login/admin logic. It scans a 4-row × 3-column active-low key matrix, synchronises and debounces the column returns, and emits each accepted key press as a single-cycle code. When no code is being emitted, the output sits at the idle code 4'b1111. It sits between the board keypad pins and the Elevator `keyPadInput` port.

## Interface
- `SCAN_DIV`, default 4: clock cycles each row is driven per scan step; must be ≥ 3.
- `DEBOUNCE`, default 3: consecutive matching samples required to accept a press or a release; must be ≥ 1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `col_n`  in  [3:1]  column returns, active-low with pull-ups, asynchronous to `clk`.
- `row_n`  out  [4:1]  row drive, active-low one-hot.
- `key_code`  out  [4:1]  accepted key code; 4'b1111 when idle.
- `key_valid`  out  1  high for exactly the cycle in which `key_code` is not 4'b1111.

## Operation
- Key layout, row 1 to row 4: `1 2 3` / `4 5 6` / `7 8 9` / `* 0 #`.
- Codes:
  - digits 0–9 map to 4'b0000–4'b1001;
  - `*` maps to 4'b1010;
  - `#` (tag) maps to 4'b1011;
  - idle is 4'b1111.
- `col_n` passes through a 2-flop synchroniser. All logic below uses the synchronised value `cols`.
- A "sample" means `cols` captured on the last cycle of a `SCAN_DIV` dwell.
- A "single hit" means exactly one bit of the sample is low. Zero or multiple low bits count as no hit.

State machine:
- **SCAN**
  - Drive rows 1→2→3→4→1, `SCAN_DIV` cycles each.
  - A single hit sets candidate = (row, col), sets count = 1 and moves to DEBOUNCE, holding the row.
- **DEBOUNCE**
  - Row held; sample every `SCAN_DIV` cycles.
  - Single hit on the same column: count+1. When count reaches `DEBOUNCE`, move to EMIT.
  - Any other sample: return to SCAN at row 1, count = 0.
  - When `DEBOUNCE` = 1, go directly from SCAN to EMIT.
- **EMIT**
  - One cycle: `key_code` = candidate code, `key_valid` = 1.
  - Then move to WAIT_RELEASE with count = 0.
- **WAIT_RELEASE**
  - Row held; sample every `SCAN_DIV` cycles.
  - All-high sample: count+1. Any low bit: count = 0.
  - When count reaches `DEBOUNCE`, return to SCAN at row 1.
  - A held key never re-emits. Presses on other rows are ignored until release completes.

## Timing
- Reset (`rst` low, asynchronous, any state including mid-debounce or EMIT):
  - `row_n` = 4'b1110;
  - `key_code` = 4'b1111, `key_valid` = 0;
  - state = SCAN, row = 1;
  - dwell counter and count = 0;
  - synchroniser flops = 3'b111.
- After `rst` deasserts, the first sample occurs at the `SCAN_DIV`-th clock edge.
- All outputs are registered; there is no combinational path from `col_n`.
- Column-to-sample latency is 2 cycles (synchroniser). This is why `SCAN_DIV` ≥ 3: the sample reflects the current row.
- Press latency: `key_valid` rises 1 + (`DEBOUNCE`−1)·`SCAN_DIV` cycles after the edge that took the first hit sample.
  - Defaults: 9 cycles.
- Minimum spacing between two pulses is 2·`DEBOUNCE`·`SCAN_DIV` cycles.
- `key_code` returns to 4'b1111 on the cycle after EMIT; it is never X.
- Counters saturate at `DEBOUNCE` and are sized `$clog2(DEBOUNCE+1)`. The dwell counter wraps 0..`SCAN_DIV`−1.
- The row index wraps from 4 to 1.

## Structure
- Shared package `keypad_pkg`, holding:
  - `KEY_0`..`KEY_9`, `KEY_STAR`, `KEY_TAG`, `KEY_NONE` (4'b1111), in the same code map as the Elevator testbench;
  - the state enum (SCAN, DEBOUNCE, EMIT, WAIT_RELEASE);
  - the row/column→code lookup function.
- One sub-module: `keypad_col_sync`, a 3-bit 2-flop synchroniser that resets to 1s.

## Test plan
All scenarios use `SCAN_DIV` = 4, `DEBOUNCE` = 3.
1. **Reset during debounce.** Assert `rst` low mid-DEBOUNCE → immediately `row_n` = 1110, `key_code` = 1111, `key_valid` = 0. After release, the first sample falls at edge 4.
2. **Held key `5`.** Press row 2/col 2 and hold 200 cycles → exactly one pulse, `key_code` = 0101, 9 cycles after the first hit. No further pulses while held. Scanning resumes at row 1 12 cycles after release.
3. **Bounce.** `7` (row 3/col 1) toggles every 3 cycles for 40 cycles, then is held stable → no pulse during bounce; one pulse `key_code` = 0111 after stabilising.
4. **Sequence `*` then `#` with release between.** → pulses 1010, then 1011; `key_valid` high exactly 2 cycles total.
5. **Two keys on one row.** `1` and `2` (row 1) pressed together → no pulse. Release `2` → one pulse 0001.
6. **One-sample glitch.** Glitch on `0` (row 4/col 2) lasting one sample → return to SCAN, no pulse, `key_code` stays 1111.
